gf180mcu_fd_sc_mcu7t5v0__crc_serial: RTL and testbench
======================================================

Name: gf180mcu_fd_sc_mcu7t5v0__crc_serial

Overview:
- Serial CRC/LFSR accumulator built directly downstream of the xor2 cells.
- Consumes one data bit per enabled clock and folds it into a shift register through xor2 feedback taps.
- Reports frame completion, a zero-remainder check result, and a frame bit count.
- Used as the parity/CRC check stage for serial links in the mcu7t5v0 library macro set.

Parameters:
- WIDTH, 8, CRC register width in bits (legal 2..32).
- POLY, 8'h07, generator polynomial, implicit x^WIDTH term omitted, MSB-first (non-reflected).
- INIT, 8'h00, value loaded into the CRC register at start of frame.
- CNTW, 8, width of the frame bit counter.

Ports:
- CLK  input  1  clock, rising-edge active
- RST  input  1  reset, asynchronous, active-high
- D  input  1  serial data bit, MSB of each byte first
- EN  input  1  D is valid this cycle
- SOF  input  1  start of frame, qualified by EN; this bit is the first bit of the frame
- EOF  input  1  end of frame, qualified by EN; this bit is the last bit of the frame
- Q  output  WIDTH  current CRC register
- CNT  output  CNTW  bits accepted in the current/last frame, saturating at all-ones
- BUSY  output  1  high while in the ACC state
- DONE  output  1  one-cycle pulse after the EOF bit is accepted
- MATCH  output  1  Q == 0 at DONE; held until next SOF
- ERR  output  1  sticky protocol error, cleared by the next accepted SOF
- VDD  inout  1  power
- VSS  inout  1  ground

Behaviour:
- Reset is asynchronous and active-high: one clock CLK; RST asynchronous, active-high.
- While RST=1: Q=INIT, CNT=0, BUSY=0, DONE=0, MATCH=0, ERR=0, state=IDLE.
- Update function: fb = D ^ Q[WIDTH-1]; Qn = {Q[WIDTH-2:0],1'b0} ^ (fb ? POLY : 0).
- On a SOF cycle, the update uses INIT in place of Q.
- States: IDLE, ACC, FIN.
- IDLE:
  - EN&SOF&~EOF -> ACC; Q=upd(INIT); CNT=1; ERR=0; MATCH=0.
  - EN&SOF&EOF -> FIN (single-bit frame); same register updates.
  - EN&~SOF -> stays IDLE; ERR=1; Q and CNT unchanged.
  - EN=0 -> all registers hold.
- ACC:
  - EN&~SOF&~EOF -> Q=upd(Q); CNT=sat(CNT+1).
  - EN&EOF&~SOF -> Q=upd(Q); CNT=sat(CNT+1); -> FIN.
  - EN&SOF (EOF either value) -> abort and restart: ERR=1; Q=upd(INIT); CNT=1; -> ACC, or FIN if EOF=1. ERR is not cleared by this SOF.
  - EN=0 -> hold; BUSY stays 1.
- FIN (exactly one cycle):
  - DONE=1; MATCH=(Q==0), registered and held until next accepted SOF.
  - An EN bit in FIN is treated as in IDLE: SOF starts a new frame, so back-to-back frames have zero gap cost; EN without SOF sets ERR.
  - Next state is IDLE unless a new frame started.
- Latency: Q and CNT reflect a bit on the edge that accepts it. DONE/MATCH assert on the edge after the EOF bit.
- CNT saturates at 2^CNTW-1; no wrap.
- Q holds its final value after FIN until the next SOF.
- EOF in IDLE without SOF: ignored, and sets ERR.
- RST asserted mid-frame: immediate return to reset values; a partial frame is discarded, with no DONE.
- X on D while EN=0 must not propagate into Q.

Test Plan:
- Defaults; frame 0x01 (8 bits MSB-first, SOF on bit 0, EOF on bit 7) -> Q=0x07, CNT=8, DONE one cycle after the EOF bit, MATCH=0, ERR=0.
- Frame 0x01 followed by 0x07 (16 bits) -> Q=0x00, CNT=16, MATCH=1; frame 0xFF -> Q=0xF3, MATCH=0.
- Frame 0xFF with EN toggling 1/0 every cycle -> Q=0xF3, CNT=8, BUSY high throughout the gaps.
- EN with SOF=0 in IDLE -> ERR=1, Q=INIT unchanged; next valid frame clears ERR. SOF mid-frame -> ERR=1, CNT=1, restarted result is correct.
- Back-to-back frames with SOF on the cycle immediately after EOF (during FIN) -> DONE pulse for frame 1 and correct CRC for frame 2; single-bit frame D=1 (SOF&EOF) -> Q=0x07, CNT=1.
- RST pulsed mid-frame, asynchronously between edges -> outputs drop to reset values immediately, no DONE; CNTW=3 with a 10-bit frame -> CNT=7.

Source files
------------

// File: rtl/gf180mcu_fd_sc_mcu7t5v0__crc_serial.sv
// Serial MSB-first CRC/LFSR accumulator with frame tracking.
// Folds one bit per enabled clock and reports DONE/MATCH/ERR and a saturating bit count.
module gf180mcu_fd_sc_mcu7t5v0__crc_serial #(
  parameter int               WIDTH = 8,
  parameter logic [WIDTH-1:0] POLY  = 8'h07,
  parameter logic [WIDTH-1:0] INIT  = 8'h00,
  parameter int               CNTW  = 8
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             D,
  input  logic             EN,
  input  logic             SOF,
  input  logic             EOF,
  output logic [WIDTH-1:0] Q,
  output logic [CNTW-1:0]  CNT,
  output logic             BUSY,
  output logic             DONE,
  output logic             MATCH,
  output logic             ERR,
  output logic [1:0]       state_dbg,
  inout  wire              VDD,
  inout  wire              VSS
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ACC  = 2'd1,
    S_FIN  = 2'd2
  } state_t;

  state_t           state, state_n;
  logic [WIDTH-1:0] q, q_n, q_base, q_upd;
  logic [CNTW-1:0]  cnt, cnt_n, cnt_inc;
  logic             match, match_n;
  logic             err, err_n;

  wire unused_pwr = VDD ^ VSS;

  function automatic logic [WIDTH-1:0] upd(input logic [WIDTH-1:0] cur, input logic bit_in);
    logic fb;
    fb  = bit_in ^ cur[WIDTH-1];
    upd = {cur[WIDTH-2:0], 1'b0} ^ (fb ? POLY : '0);
  endfunction

  // A SOF bit always starts from INIT, whatever the register currently holds.
  assign q_base  = SOF ? INIT : q;
  assign q_upd   = upd(q_base, D);
  assign cnt_inc = (&cnt) ? cnt : cnt + 1'b1;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state <= S_IDLE;
      q     <= INIT;
      cnt   <= '0;
      match <= 1'b0;
      err   <= 1'b0;
    end else begin
      state <= state_n;
      q     <= q_n;
      cnt   <= cnt_n;
      match <= match_n;
      err   <= err_n;
    end
  end

  always_comb begin
    state_n = (state == S_FIN) ? S_IDLE : state;
    q_n     = q;
    cnt_n   = cnt;
    match_n = match;
    err_n   = err;
    // Nothing is sampled from D unless EN is high, so X on idle cycles cannot reach q.
    if (EN) begin
      unique case (state)
        S_IDLE, S_FIN: begin
          if (SOF) begin
            q_n     = q_upd;
            cnt_n   = CNTW'(1);
            err_n   = 1'b0;
            match_n = EOF ? (q_upd == '0) : 1'b0;
            state_n = EOF ? S_FIN : S_ACC;
          end else begin
            err_n   = 1'b1;
            state_n = S_IDLE;
          end
        end
        S_ACC: begin
          q_n = q_upd;
          if (SOF) begin
            cnt_n   = CNTW'(1);
            err_n   = 1'b1;
            match_n = EOF ? (q_upd == '0) : 1'b0;
          end else begin
            cnt_n   = cnt_inc;
            if (EOF) match_n = (q_upd == '0);
          end
          state_n = EOF ? S_FIN : S_ACC;
        end
        default: state_n = S_IDLE;
      endcase
    end
  end

  assign Q         = q;
  assign CNT       = cnt;
  assign BUSY      = (state == S_ACC);
  assign DONE      = (state == S_FIN);
  assign MATCH     = match;
  assign ERR       = err;
  assign state_dbg = state;

endmodule

// File: tb/tb_gf180mcu_fd_sc_mcu7t5v0__crc_serial.sv
// Directed bench for the serial CRC block: a frame vector table plus hand-written corner sequences.
module tb_gf180mcu_fd_sc_mcu7t5v0__crc_serial;

  logic       clk, rst, d, en, sof, eof;
  logic [7:0] q, cnt;
  logic       busy, done, match, err;
  logic [1:0] st;
  logic [7:0] q2;
  logic [2:0] cnt2;
  logic       busy2, done2, match2, err2;
  logic [1:0] st2;
  wire        vdd = 1'b1;
  wire        vss = 1'b0;

  int total = 0;
  int bad   = 0;

  gf180mcu_fd_sc_mcu7t5v0__crc_serial dut (
    .CLK(clk), .RST(rst), .D(d), .EN(en), .SOF(sof), .EOF(eof),
    .Q(q), .CNT(cnt), .BUSY(busy), .DONE(done), .MATCH(match), .ERR(err),
    .state_dbg(st), .VDD(vdd), .VSS(vss)
  );

  gf180mcu_fd_sc_mcu7t5v0__crc_serial #(.CNTW(3)) dut_c3 (
    .CLK(clk), .RST(rst), .D(d), .EN(en), .SOF(sof), .EOF(eof),
    .Q(q2), .CNT(cnt2), .BUSY(busy2), .DONE(done2), .MATCH(match2), .ERR(err2),
    .state_dbg(st2), .VDD(vdd), .VSS(vss)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    bad++;
    $display("test done: total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [31:0] bits;
    int          n;
    logic        gap;
    logic [7:0]  q;
    logic [7:0]  cnt;
    logic        match;
  } vec_t;

  vec_t vecs[7];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic drive_bit(input logic b, input logic s, input logic e);
    d = b; en = 1'b1; sof = s; eof = e;
    tick();
    en = 1'b0; sof = 1'b0; eof = 1'b0; d = 1'bx;
  endtask

  // MSB-first frame; with gap set, an idle cycle follows every bit but the last.
  task automatic send_frame(input logic [31:0] bits, input int n, input logic gap);
    for (int i = n - 1; i >= 0; i--) begin
      drive_bit(bits[i], i == n - 1, i == 0);
      if (gap && i != 0) begin
        tick();
        chk("gap_busy", {31'b0, busy}, 32'd1);
      end
    end
  endtask

  initial begin
    vecs[0] = '{32'h01,   8,  1'b0, 8'h07, 8'd8,  1'b0};
    vecs[1] = '{32'h0107, 16, 1'b0, 8'h00, 8'd16, 1'b1};
    vecs[2] = '{32'hFF,   8,  1'b0, 8'hF3, 8'd8,  1'b0};
    vecs[3] = '{32'hFF,   8,  1'b1, 8'hF3, 8'd8,  1'b0};
    vecs[4] = '{32'h1,    1,  1'b0, 8'h07, 8'd1,  1'b0};
    vecs[5] = '{32'h00,   8,  1'b0, 8'h00, 8'd8,  1'b1};
    vecs[6] = '{32'h2,    2,  1'b0, 8'h0E, 8'd2,  1'b0};

    rst = 1'b1; d = 1'b0; en = 1'b0; sof = 1'b0; eof = 1'b0;
    tick(); tick();
    chk("rst_q", {24'b0, q}, 32'h00);
    chk("rst_cnt", {24'b0, cnt}, 32'd0);
    chk("rst_flags", {28'b0, busy, done, match, err}, 32'd0);
    rst = 1'b0;
    tick();
    chk("idle_hold_q", {24'b0, q}, 32'h00);

    // frame table
    for (int v = 0; v < 7; v++) begin
      send_frame(vecs[v].bits, vecs[v].n, vecs[v].gap);
      chk($sformatf("v%0d_done", v), {31'b0, done}, 32'd1);
      chk($sformatf("v%0d_q", v), {24'b0, q}, {24'b0, vecs[v].q});
      chk($sformatf("v%0d_cnt", v), {24'b0, cnt}, {24'b0, vecs[v].cnt});
      chk($sformatf("v%0d_match", v), {31'b0, match}, {31'b0, vecs[v].match});
      chk($sformatf("v%0d_err", v), {31'b0, err}, 32'd0);
      chk($sformatf("v%0d_busy", v), {31'b0, busy}, 32'd0);
      tick();
      chk($sformatf("v%0d_done_pulse", v), {31'b0, done}, 32'd0);
      chk($sformatf("v%0d_q_hold", v), {24'b0, q}, {24'b0, vecs[v].q});
      chk($sformatf("v%0d_match_hold", v), {31'b0, match}, {31'b0, vecs[v].match});
    end

    // back-to-back: 0xFF then 0x01, second SOF lands in the FIN cycle
    begin
      logic [15:0] bb;
      bb = 16'hFF01;
      for (int i = 0; i < 16; i++) begin
        drive_bit(bb[15 - i], i == 0 || i == 8, i == 7 || i == 15);
        if (i == 7) begin
          chk("bb_done1", {31'b0, done}, 32'd1);
          chk("bb_q1", {24'b0, q}, 32'hF3);
          chk("bb_cnt1", {24'b0, cnt}, 32'd8);
        end
        if (i == 8) begin
          chk("bb_restart_busy", {31'b0, busy}, 32'd1);
          chk("bb_restart_cnt", {24'b0, cnt}, 32'd1);
        end
      end
      chk("bb_done2", {31'b0, done}, 32'd1);
      chk("bb_q2", {24'b0, q}, 32'h07);
      chk("bb_err", {31'b0, err}, 32'd0);
      tick();
    end

    // SOF mid-frame restarts and sets ERR, which survives the restart
    for (int i = 0; i < 4; i++) drive_bit(1'b1, i == 0, 1'b0);
    drive_bit(1'b0, 1'b1, 1'b0);
    chk("abort_err", {31'b0, err}, 32'd1);
    chk("abort_cnt", {24'b0, cnt}, 32'd1);
    for (int i = 6; i >= 0; i--) drive_bit(i == 0, 1'b0, i == 0);
    chk("abort_q", {24'b0, q}, 32'h07);
    chk("abort_cnt_end", {24'b0, cnt}, 32'd8);
    chk("abort_err_end", {31'b0, err}, 32'd1);
    chk("abort_done", {31'b0, done}, 32'd1);
    tick();

    // async reset between edges in the middle of a frame
    for (int i = 0; i < 4; i++) drive_bit(1'b1, i == 0, 1'b0);
    chk("pre_rst_busy", {31'b0, busy}, 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("arst_q", {24'b0, q}, 32'h00);
    chk("arst_cnt", {24'b0, cnt}, 32'd0);
    chk("arst_flags", {28'b0, busy, done, match, err}, 32'd0);
    #2 rst = 1'b0;
    tick();
    chk("arst_no_done", {31'b0, done}, 32'd0);
    tick();
    chk("arst_no_done2", {31'b0, done}, 32'd0);

    // EN without SOF in IDLE, then EOF alone
    drive_bit(1'b1, 1'b0, 1'b0);
    chk("idle_en_err", {31'b0, err}, 32'd1);
    chk("idle_en_q", {24'b0, q}, 32'h00);
    chk("idle_en_cnt", {24'b0, cnt}, 32'd0);
    drive_bit(1'b1, 1'b0, 1'b1);
    chk("idle_eof_done", {31'b0, done}, 32'd0);
    chk("idle_eof_err", {31'b0, err}, 32'd1);
    send_frame(32'h01, 8, 1'b0);
    chk("err_clear", {31'b0, err}, 32'd0);
    chk("err_clear_q", {24'b0, q}, 32'h07);
    tick();

    // counter saturation: 10-bit frame on an 8-bit and a 3-bit counter
    send_frame(32'h3FF, 10, 1'b0);
    chk("c8_cnt10", {24'b0, cnt}, 32'd10);
    chk("c3_sat", {29'b0, cnt2}, 32'd7);
    chk("c3_done", {31'b0, done2}, 32'd1);
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
